// File: rtl/logic_alu_pkg.sv
// ---------------------------------------------------------------------------
// logic_alu_pkg
// Shared definitions for the logic_alu_ctrl slice:
//   - alu_op_e       : 3-bit opcode encoding (AND, OR, XOR, SHR, SHL)
//   - OP_ILLEGAL_MIN : first opcode value that is treated as illegal
//   - alu_state_e    : controller FSM states
//   - is_shift / is_illegal : opcode classification helpers
// Build option: LOGIC_ALU_CTRL_RR_EN (used by alu_rr_arb, not by this file).
// ---------------------------------------------------------------------------
package logic_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_SHR = 3'd3,
        OP_SHL = 3'd4
    } alu_op_e;

    localparam logic [2:0] OP_ILLEGAL_MIN = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Shift opcodes are the only ones that spend extra cycles in EXEC.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

    // Opcodes at or above the threshold produce a zero result with err set.
    function automatic logic is_illegal(input logic [2:0] op);
        return op >= OP_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// ---------------------------------------------------------------------------
// alu_rr_arb
// Two-input arbiter for the logic ALU controller.
// Ports:
//   clk, rst  : clock / async active-high reset (only with LOGIC_ALU_CTRL_RR_EN)
//   valid0/1  : requester has an operation pending
//   accept    : controller can take a request this cycle
//   grant     : index of the requester that wins this cycle
//   ready     : one-hot ready vector, zero unless accept and some valid
// Build option: LOGIC_ALU_CTRL_RR_EN selects round-robin arbitration with a
// last-grant register; otherwise requester 0 has fixed priority.
// ---------------------------------------------------------------------------
module alu_rr_arb (
`ifdef LOGIC_ALU_CTRL_RR_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic       valid0,
    input  logic       valid1,
    input  logic       accept,
    output logic       grant,
    output logic [1:0] ready
);

`ifdef LOGIC_ALU_CTRL_RR_EN
    logic last_grant;

    // On contention, hand the grant to whoever did not win last time.
    // A lone requester wins regardless of history.
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (!valid0) begin
            grant = 1'b1;
        end
    end

    // Remember the winner of every accepted request. Reset value 1 makes
    // requester 0 the first winner on contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept && (valid0 || valid1)) begin
            last_grant <= grant;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        grant = ~valid0;
    end
`endif

    // Ready goes only to the winner, and only when a request is actually taken.
    always_comb begin
        ready = 2'b00;
        if (accept && (valid0 || valid1)) begin
            ready = grant ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/logic_alu_ctrl.sv
// ---------------------------------------------------------------------------
// logic_alu_ctrl
// Two-requester bitwise/shift ALU with an IDLE -> EXEC -> DONE controller.
// Shifts are performed one bit per cycle, so their latency grows with the
// shift amount (clamped to N).
// Parameter: N = operand/result width.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   reqX_valid/op/a/b, reqX_ready  : requester X handshake and operands
//   res_valid, res_ready           : result handshake
//   res_data, res_id, res_err      : result value, issuing requester, illegal op
//   busy                           : controller is not in IDLE
// Build option: LOGIC_ALU_CTRL_RR_EN enables round-robin arbitration.
// ---------------------------------------------------------------------------
module logic_alu_ctrl
    import logic_alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [2:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [2:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_id,
    output logic         res_err,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);

    alu_state_e    state_q, state_d;
    logic [2:0]    op_q;
    logic [N-1:0]  work_q, b_q, res_q;
    logic [CW-1:0] cnt_q, shift_load;
    logic          id_q, err_q;
    logic          accept, grant, take;
    logic [1:0]    arb_ready;
    logic [2:0]    sel_op;
    logic [N-1:0]  sel_a, sel_b, exec_result;

    // Requests may only be taken in IDLE, and never while reset is held.
    always_comb begin
        accept = (state_q == ST_IDLE) && !rst;
    end

    alu_rr_arb u_arb (
`ifdef LOGIC_ALU_CTRL_RR_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant  (grant),
        .ready  (arb_ready)
    );

    assign req0_ready = arb_ready[0];
    assign req1_ready = arb_ready[1];
    assign take       = |arb_ready;
    assign busy       = (state_q != ST_IDLE);
    assign res_valid  = (state_q == ST_DONE);
    assign res_data   = res_q;
    assign res_id     = id_q;
    assign res_err    = err_q;

    // Route the winning requester's operation towards the capture registers,
    // and work out how many single-bit shift steps it needs. Shift amounts of
    // N or more are clamped to N, which already clears every bit.
    always_comb begin
        sel_op     = grant ? req1_op : req0_op;
        sel_a      = grant ? req1_a  : req0_a;
        sel_b      = grant ? req1_b  : req0_b;
        shift_load = '0;
        if (is_shift(sel_op)) begin
            if (int'(sel_b) >= N) begin
                shift_load = CW'(N);
            end else begin
                shift_load = CW'(sel_b);
            end
        end
    end

    // Final value written to the result register when the shift count has
    // run out. For shifts the working register already holds the answer.
    always_comb begin
        exec_result = '0;
        case (op_q)
            OP_AND:         exec_result = work_q & b_q;
            OP_OR:          exec_result = work_q | b_q;
            OP_XOR:         exec_result = work_q ^ b_q;
            OP_SHR, OP_SHL: exec_result = work_q;
            default:        exec_result = '0;
        endcase
    end

    // Controller next state: leave IDLE on an accept, leave EXEC once the
    // shift counter is exhausted, leave DONE when the consumer takes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (take)          state_d = ST_EXEC;
            ST_EXEC: if (cnt_q == '0)   state_d = ST_DONE;
            ST_DONE: if (res_ready)     state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // State register plus datapath. The working register doubles as operand a
    // for bitwise ops and as the shifting value for shift ops. Reset wipes any
    // operation in flight so no result is ever delivered for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            work_q  <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        op_q   <= sel_op;
                        work_q <= sel_a;
                        b_q    <= sel_b;
                        id_q   <= grant;
                        cnt_q  <= shift_load;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q != '0) begin
                        work_q <= (op_q == OP_SHR) ? (work_q >> 1) : (work_q << 1);
                        cnt_q  <= cnt_q - CW'(1);
                    end else begin
                        res_q <= exec_result;
                        err_q <= is_illegal(op_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_logic_alu_ctrl
// Self-checking bench for logic_alu_ctrl (N=4): a directed vector table,
// reset corner cases, then randomized operations checked against a
// behavioural model. Honours LOGIC_ALU_CTRL_RR_EN for expected grant order.
// ---------------------------------------------------------------------------
module tb_logic_alu_ctrl;

    localparam int N = 4;

    typedef struct {
        logic         v0;
        logic [2:0]   op0;
        logic [N-1:0] a0;
        logic [N-1:0] b0;
        logic         v1;
        logic [2:0]   op1;
        logic [N-1:0] a1;
        logic [N-1:0] b1;
        int           hold;
        logic         exp_id;
        logic [N-1:0] exp_data;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [2:0]   req0_op = '0;
    logic [N-1:0] req0_a = '0;
    logic [N-1:0] req0_b = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [2:0]   req1_op = '0;
    logic [N-1:0] req1_a = '0;
    logic [N-1:0] req1_b = '0;
    logic         req1_ready;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] res_data;
    logic         res_id;
    logic         res_err;
    logic         busy;

    int   vectors     = 0;
    int   miscompares = 0;
    logic model_last  = 1'b1;

    vec_t tbl [13];

    always #5 clk = ~clk;

    logic_alu_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_err    (res_err),
        .busy       (busy)
    );

    function automatic vec_t mk(input logic v0, input logic [2:0] op0,
                                input logic [N-1:0] a0, input logic [N-1:0] b0,
                                input logic v1, input logic [2:0] op1,
                                input logic [N-1:0] a1, input logic [N-1:0] b1,
                                input int hold, input logic id,
                                input logic [N-1:0] data, input logic err, input int lat);
        vec_t v;
        v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
        v.hold = hold; v.exp_id = id; v.exp_data = data; v.exp_err = err; v.exp_lat = lat;
        return v;
    endfunction

    // Behavioural reference: arbitration rule, whole-word result, latency formula.
    function automatic vec_t modelFill(input vec_t v);
        vec_t         r;
        logic         g;
        logic [2:0]   op;
        logic [N-1:0] a, b;
        int           amt;
        r = v;
`ifdef LOGIC_ALU_CTRL_RR_EN
        g = (v.v0 && v.v1) ? ~model_last : ~v.v0;
`else
        g = ~v.v0;
`endif
        op = g ? v.op1 : v.op0;
        a  = g ? v.a1  : v.a0;
        b  = g ? v.b1  : v.b0;
        amt = (int'(b) > N) ? N : int'(b);
        r.exp_id  = g;
        r.exp_err = 1'b0;
        r.exp_lat = 2;
        case (op)
            3'd0: r.exp_data = a & b;
            3'd1: r.exp_data = a | b;
            3'd2: r.exp_data = a ^ b;
            3'd3: begin r.exp_data = a >> b; r.exp_lat = 2 + amt; end
            3'd4: begin r.exp_data = a << b; r.exp_lat = 2 + amt; end
            default: begin r.exp_data = '0; r.exp_err = 1'b1; end
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
        res_ready  = 1'b0;
    endtask

    // One full operation: accept cycle, EXEC wait, DONE hold, handshake.
    // Returns right after raising res_ready in the final DONE cycle.
    task automatic runOne(input vec_t v);
        int cyc;
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput("accept_busy", 32'(busy), 32'(0));
        checkOutput("accept_ready0", 32'(req0_ready), 32'(v.exp_id == 1'b0));
        checkOutput("accept_ready1", 32'(req1_ready), 32'(v.exp_id == 1'b1));
        model_last = v.exp_id;
        cyc = 0;
        do begin
            @(negedge clk);
            if (cyc == 0) begin
                if (v.exp_id) req1_valid = 1'b0;
                else          req0_valid = 1'b0;
                res_ready = (v.hold == 0);
            end
            #1;
            cyc++;
            if (!res_valid) checkOutput("ready_in_exec", 32'({req0_ready, req1_ready}), 32'(0));
        end while (!res_valid && cyc < v.exp_lat + 8);
        checkOutput("latency", 32'(cyc), 32'(v.exp_lat));
        checkOutput("res_valid", 32'(res_valid), 32'(1));
        checkOutput("res_data", 32'(res_data), 32'(v.exp_data));
        checkOutput("res_id", 32'(res_id), 32'(v.exp_id));
        checkOutput("res_err", 32'(res_err), 32'(v.exp_err));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            #1;
            checkOutput("hold_valid", 32'(res_valid), 32'(1));
            checkOutput("hold_data", 32'({res_id, res_err, res_data}),
                        32'({v.exp_id, v.exp_err, v.exp_data}));
            checkOutput("ready_in_done", 32'({req0_ready, req1_ready}), 32'(0));
        end
        res_ready = 1'b1;
        checkOutput("ready_at_handshake", 32'({req0_ready, req1_ready}), 32'(0));
    endtask

    initial begin
        vec_t r;
        int   seen;

        tbl[0]  = mk(1, 3'd0, 4'b1100, 4'b1010, 0, 3'd0, 4'b0000, 4'b0000, 0, 0, 4'b1000, 0, 2);
        tbl[1]  = mk(0, 3'd0, 4'b0000, 4'b0000, 1, 3'd4, 4'b0011, 4'd2,    1, 1, 4'b1100, 0, 4);
        tbl[2]  = mk(0, 3'd0, 4'b0000, 4'b0000, 1, 3'd3, 4'b1000, 4'd7,    0, 1, 4'b0000, 0, 6);
        tbl[3]  = mk(1, 3'd2, 4'b0101, 4'b1111, 0, 3'd0, 4'b0000, 4'b0000, 5, 0, 4'b1010, 0, 2);
        tbl[4]  = mk(1, 3'd6, 4'b1111, 4'b0011, 0, 3'd0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 1, 2);
        tbl[5]  = mk(1, 3'd4, 4'b1111, 4'd4,    0, 3'd0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 6);
        tbl[6]  = mk(1, 3'd3, 4'b1011, 4'd0,    0, 3'd0, 4'b0000, 4'b0000, 2, 0, 4'b1011, 0, 2);
        tbl[7]  = mk(0, 3'd0, 4'b0000, 4'b0000, 1, 3'd7, 4'b0101, 4'b0000, 0, 1, 4'b0000, 1, 2);
        tbl[8]  = mk(0, 3'd0, 4'b0000, 4'b0000, 1, 3'd4, 4'b0001, 4'd3,    0, 1, 4'b1000, 0, 5);
`ifdef LOGIC_ALU_CTRL_RR_EN
        tbl[9]  = mk(1, 3'd1, 4'b0011, 4'b0100, 1, 3'd0, 4'b1111, 4'b0101, 0, 0, 4'b0111, 0, 2);
        tbl[10] = mk(1, 3'd1, 4'b0011, 4'b0100, 1, 3'd0, 4'b1111, 4'b0101, 0, 1, 4'b0101, 0, 2);
        tbl[11] = mk(1, 3'd1, 4'b0011, 4'b0100, 1, 3'd0, 4'b1111, 4'b0101, 1, 0, 4'b0111, 0, 2);
        tbl[12] = mk(1, 3'd1, 4'b0011, 4'b0100, 1, 3'd0, 4'b1111, 4'b0101, 0, 1, 4'b0101, 0, 2);
`else
        tbl[9]  = mk(1, 3'd1, 4'b0011, 4'b0100, 1, 3'd0, 4'b1111, 4'b0101, 0, 0, 4'b0111, 0, 2);
        tbl[10] = mk(1, 3'd1, 4'b0011, 4'b0100, 1, 3'd0, 4'b1111, 4'b0101, 0, 0, 4'b0111, 0, 2);
        tbl[11] = mk(1, 3'd1, 4'b0011, 4'b0100, 1, 3'd0, 4'b1111, 4'b0101, 1, 0, 4'b0111, 0, 2);
        tbl[12] = mk(1, 3'd1, 4'b0011, 4'b0100, 1, 3'd0, 4'b1111, 4'b0101, 0, 0, 4'b0111, 0, 2);
`endif

        // Reset state, with a request already pending that must not be readied.
        applyStimulus(tbl[0]);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_ready", 32'({req0_ready, req1_ready}), 32'(0));
        checkOutput("rst_outputs", 32'({res_valid, busy, res_id, res_err, res_data}), 32'(0));

        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        model_last = 1'b1;

        $display("[TB] directed table");
        for (int i = 0; i < 13; i++) begin
            runOne(tbl[i]);
        end

        @(negedge clk);
        res_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checkOutput("idle_after_table", 32'({busy, res_valid}), 32'(0));

        $display("[TB] reset during EXEC");
        @(negedge clk);
        applyStimulus(mk(1, 3'd4, 4'b0011, 4'd3, 0, 3'd0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 5));
        #1;
        checkOutput("rst_exec_accept", 32'(req0_ready), 32'(1));
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_exec_busy", 32'({busy, res_valid}), 32'(2));
        rst = 1'b1;
        #1;
        checkOutput("rst_exec_clear", 32'({res_valid, busy, res_id, res_err, res_data}), 32'(0));
        checkOutput("rst_exec_ready", 32'({req0_ready, req1_ready}), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (res_valid || busy) seen++;
        end
        checkOutput("no_result_after_rst", 32'(seen), 32'(0));

        $display("[TB] randomized operations");
        r = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), N'($urandom), N'($urandom),
               1'b1, 3'($urandom_range(0, 7)), N'($urandom), N'($urandom), 0, 0, '0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            r.hold = $urandom_range(0, 3);
            r = modelFill(r);
            runOne(r);
            if (r.exp_id) begin
                r.v1 = 1'($urandom_range(0, 1)); r.op1 = 3'($urandom_range(0, 7));
                r.a1 = N'($urandom); r.b1 = N'($urandom);
            end else begin
                r.v0 = 1'($urandom_range(0, 1)); r.op0 = 3'($urandom_range(0, 7));
                r.a0 = N'($urandom); r.b0 = N'($urandom);
            end
            if (!r.v0 && !r.v1) begin
                if (r.exp_id) r.v1 = 1'b1;
                else          r.v0 = 1'b1;
            end
        end

        @(negedge clk);
        res_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checkOutput("final_idle", 32'({busy, res_valid}), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
